dbus_xfer_master: RTL and testbench
===================================

// Module: dbus_xfer_master
// PURPOSE
//  Data-bus transfer master sitting directly upstream of the bus-interface/arbiter stage.
//  Converts a local 'go' command or a snoop-hit-modified event into a full bus transaction:
//   - arbitration request (req/grant)
//   - data-bus grant (dgrant)
//   - framed multi-beat burst (frame/dbus_enb/data_last), with wait states via dbusy_n
//  Flags stalled arbitration with time_out. Its outputs feed the bus-interface/arbiter stage.
// PARAMETERS
//  MAX_BEATS  16  max burst length; len input is $clog2(MAX_BEATS) bits, value 0 means MAX_BEATS
//  WB_BEATS   4   fixed burst length of a snoop writeback
//  TIMEOUT    32  cycles allowed in REQ or DGNT before abort; counter is $clog2(TIMEOUT+1) bits
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  go           in   1   start request; sampled only in IDLE with no writeback pending
//  len          in   LW  beats for the go transfer, latched at go
//  snoop        in   1   snoop cycle valid
//  hit_modified in   1   snoop hit a modified line; qualified by snoop
//  grant        in   1   arbitration grant
//  dgrant       in   1   data-bus grant
//  dbusy_n      in   1   1 = target accepts the current beat; 0 = wait state
//  req          out  1   bus request
//  frame        out  1   burst in progress
//  dbus_enb     out  1   data driver enable; equals frame
//  data_last    out  1   current beat is the final one
//  writeback    out  1   current transaction is a snoop writeback
//  busy         out  1   state != IDLE
//  time_out     out  1   one-cycle abort pulse
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - State goes to IDLE, beat and timeout counters clear, wb_pending clears.
//   - All outputs are 0. All outputs are registered.
//  wb_pending:
//   - Set on any cycle with snoop & hit_modified, in any state.
//   - Cleared when a writeback transaction leaves IDLE.
//   - A second hit while already pending is absorbed (no queue).
//  IDLE:
//   - If wb_pending, or snoop & hit_modified this cycle: go to REQ with
//     beats=WB_BEATS, writeback=1. Writeback has priority over go; the go is ignored, not queued.
//   - Else if go: go to REQ with beats = len (0 means MAX_BEATS), writeback=0.
//  REQ:
//   - req=1, busy=1.
//   - grant: go to DGNT, timeout counter clears.
//   - Else counter increments; after TIMEOUT cycles without grant:
//     time_out=1 for one cycle, then IDLE. A writeback aborted here re-sets wb_pending.
//  DGNT:
//   - req=1. dgrant: go to XFER; req drops on the XFER entry cycle.
//   - Same timeout rule as REQ.
//  XFER:
//   - frame=dbus_enb=1.
//   - A beat completes on each cycle with dbusy_n=1; the remaining-beats count decrements.
//   - data_last=1 while remaining==1, and holds through dbusy_n=0 wait states.
//   - Last beat accepted: next cycle IDLE; frame, data_last and writeback all drop together.
//   - grant/dgrant deassertion during XFER is ignored; the burst completes.
//   - No timeout in XFER.
//   - Minimum transaction: go, then REQ, DGNT, one XFER beat, then IDLE.
//     A 1-beat burst has frame and data_last high in the same cycle.
//  Simultaneous events:
//   - go and snoop hit in IDLE: writeback wins.
//   - grant and timeout expiry in the same cycle: grant wins.
//  Mid-operation reset: outputs drop asynchronously; no partial-burst recovery.
//  Counters never wrap: beat count saturates at 0, timeout counter at TIMEOUT.
//  Assertion targets:
//   - data_last implies frame.
//   - frame implies !req.
//   - time_out implies !frame.
//   - Each frame burst contains exactly N beats with dbusy_n=1.
// TESTING
//  T1 go=1, len=3; grant at +2, dgrant at +1, dbusy_n=1
//     -> frame high 3 cycles, data_last on the 3rd, busy drops the next cycle.
//  T2 len=0 with dbusy_n toggling 1,0 -> 16 accepted beats.
//     data_last stays high through the final wait state.
//  T3 grant never asserted -> req high 32 cycles, time_out pulse once, then IDLE.
//     A go one cycle later is accepted.
//  T4 snoop & hit_modified together with go in IDLE -> writeback=1 burst of 4 beats.
//     The go is dropped.
//  T5 snoop hit during a 5-beat go burst -> burst completes,
//     then an immediate 4-beat writeback.
//  T6 reset_n low in XFER beat 2 of 8 -> all outputs 0 asynchronously.
//     After release, IDLE and wb_pending is clear.

Source files
------------

// File: rtl/dbus_xfer_master.sv
// Data-bus transfer master: turns a local go or a snoop hit on a modified line into
// a req/grant -> dgrant -> framed burst sequence, aborting with time_out on a stalled arbiter.
module dbus_xfer_master #(
  parameter int MAX_BEATS = 16,
  parameter int WB_BEATS  = 4,
  parameter int TIMEOUT   = 32,
  localparam int LW = $clog2(MAX_BEATS),
  localparam int BW = $clog2(MAX_BEATS + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic [LW-1:0] len,
  input  logic          snoop,
  input  logic          hit_modified,
  input  logic          grant,
  input  logic          dgrant,
  input  logic          dbusy_n,
  output logic          req,
  output logic          frame,
  output logic          dbus_enb,
  output logic          data_last,
  output logic          writeback,
  output logic          busy,
  output logic          time_out
);

  typedef enum logic [1:0] {IDLE, REQ, DGNT, XFER} state_t;

  localparam logic [BW-1:0] WB_LEN  = BW'(WB_BEATS);
  localparam logic [BW-1:0] MAX_LEN = BW'(MAX_BEATS);
  localparam logic [BW-1:0] ONE     = BW'(1);
  localparam logic [BW-1:0] TWO     = BW'(2);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [BW-1:0] remain;
  logic [TW-1:0] tcnt;
  logic          wb_pending;
  logic          hit;
  logic          tmo;
  logic          arb_win;
  logic [BW-1:0] go_len;

  assign hit      = snoop & hit_modified;
  assign go_len   = (len == '0) ? MAX_LEN : BW'(len);
  // tcnt counts completed waiting cycles; this is the last one allowed
  assign tmo      = (tcnt >= TO_LAST);
  assign arb_win  = (state == REQ) ? grant : dgrant;
  assign dbus_enb = frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      remain     <= '0;
      tcnt       <= '0;
      wb_pending <= 1'b0;
      req        <= 1'b0;
      frame      <= 1'b0;
      data_last  <= 1'b0;
      writeback  <= 1'b0;
      busy       <= 1'b0;
      time_out   <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (hit) wb_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          // a hit arriving this cycle is consumed by the writeback it launches
          if (wb_pending || hit) begin
            state      <= REQ;
            remain     <= WB_LEN;
            writeback  <= 1'b1;
            wb_pending <= 1'b0;
            req        <= 1'b1;
            busy       <= 1'b1;
            tcnt       <= '0;
          end else if (go) begin
            state     <= REQ;
            remain    <= go_len;
            writeback <= 1'b0;
            req       <= 1'b1;
            busy      <= 1'b1;
            tcnt      <= '0;
          end
        end
        REQ, DGNT: begin
          if (arb_win) begin
            tcnt <= '0;
            if (state == REQ) begin
              state <= DGNT;
            end else begin
              state     <= XFER;
              req       <= 1'b0;
              frame     <= 1'b1;
              data_last <= (remain == ONE);
            end
          end else if (tmo) begin
            state     <= IDLE;
            req       <= 1'b0;
            busy      <= 1'b0;
            writeback <= 1'b0;
            time_out  <= 1'b1;
            tcnt      <= '0;
            if (writeback) wb_pending <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        XFER: begin
          if (dbusy_n) begin
            if (remain <= ONE) begin
              state     <= IDLE;
              remain    <= '0;
              frame     <= 1'b0;
              data_last <= 1'b0;
              writeback <= 1'b0;
              busy      <= 1'b0;
            end else begin
              remain    <= remain - ONE;
              data_last <= (remain == TWO);
            end
          end
        end
      endcase
    end
  end

  a_last_in_frame: assert property (@(posedge clk) disable iff (!reset_n) data_last |-> frame);
  a_frame_no_req:  assert property (@(posedge clk) disable iff (!reset_n) frame |-> !req);
  a_tmo_no_frame:  assert property (@(posedge clk) disable iff (!reset_n) time_out |-> !frame);

endmodule

// File: tb/tb_dbus_xfer_master.sv
// Directed bench: stimulus pushes expected bursts/timeouts to a queue; a negedge monitor
// reconstructs each burst from the pins and compares against the queue head.
module tb_dbus_xfer_master;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0, snoop = 1'b0, hit_modified = 1'b0;
  logic          grant = 1'b0, dgrant = 1'b0, dbusy_n = 1'b1;
  logic [LW-1:0] len = '0;
  logic          req, frame, dbus_enb, data_last, writeback, busy, time_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit to;
    int beats;   // accepted beats, or req-high cycles for a timeout
    int fcyc;
    bit wb;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  dbus_xfer_master dut (
    .clk(clk), .reset_n(reset_n), .go(go), .len(len), .snoop(snoop),
    .hit_modified(hit_modified), .grant(grant), .dgrant(dgrant), .dbusy_n(dbusy_n),
    .req(req), .frame(frame), .dbus_enb(dbus_enb), .data_last(data_last),
    .writeback(writeback), .busy(busy), .time_out(time_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input bit to, input int beats, input int fcyc, input bit wb);
    exp_t e;
    e.to = to; e.beats = beats; e.fcyc = fcyc; e.wb = wb;
    expq.push_back(e);
  endtask

  // monitor state
  bit   in_b = 0, b_wb = 0, b_dlseen = 0, b_dlbad = 0;
  int   b_beats = 0, b_cyc = 0, b_dlacc = 0, req_run = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_b    = 0;
      req_run = 0;
    end else begin
      if ((data_last && !frame) || (frame && req) || (time_out && frame) || (dbus_enb != frame)) begin
        miscompares++;
        $display("FAIL invariant: last=%0b frame=%0b req=%0b tmo=%0b enb=%0b",
                 data_last, frame, req, time_out, dbus_enb);
      end
      if (frame) begin
        if (!in_b) begin
          in_b = 1; b_beats = 0; b_cyc = 0; b_dlacc = 0;
          b_wb = writeback; b_dlseen = 0; b_dlbad = 0;
        end
        b_cyc++;
        if (b_dlseen && !data_last) b_dlbad = 1;
        if (data_last) b_dlseen = 1;
        if (dbusy_n) begin
          b_beats++;
          if (data_last) b_dlacc++;
        end
      end else if (in_b) begin
        in_b = 0;
        if (expq.size() == 0 || expq[0].to) begin
          miscompares++;
          $display("FAIL burst_unexpected: got burst of %0d beats, expected none", b_beats);
        end else begin
          e = expq.pop_front();
          chk("burst_beats", b_beats, e.beats);
          chk("burst_frame_cycles", b_cyc, e.fcyc);
          chk("burst_writeback", int'(b_wb), int'(e.wb));
          chk("burst_last_on_final_beat", b_dlacc, 1);
          chk("burst_last_held", int'(b_dlbad), 0);
        end
      end
      if (time_out) begin
        if (expq.size() == 0 || !expq[0].to) begin
          miscompares++;
          $display("FAIL timeout_unexpected: got time_out, expected none");
        end else begin
          e = expq.pop_front();
          chk("timeout_req_cycles", req_run, e.beats);
        end
      end
      req_run = req ? req_run + 1 : 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int l, input bit hit);
    len = LW'(l); go = 1'b1; snoop = hit; hit_modified = hit;
    cyc(1);
    go = 1'b0; snoop = 1'b0; hit_modified = 1'b0;
  endtask

  // Arbiter + target responder for one transaction
  task automatic serve(input int gdly, input int ddly, input bit toggle,
                       input int snoop_at, input int abort_at);
    int n;
    bit ph;
    n = 0;
    while (!req && n < 50) begin cyc(1); n++; end
    chk("req_seen", int'(req), 1);
    if (!req) return;
    cyc(gdly);
    grant = 1'b1; cyc(1); grant = 1'b0;
    cyc(ddly);
    dgrant = 1'b1; cyc(1); dgrant = 1'b0;
    chk("frame_start", int'(frame), 1);
    if (!frame) return;
    n = 0; ph = 1'b1;
    while (frame && n < 100) begin
      dbusy_n = toggle ? ph : 1'b1;
      ph = ~ph;
      if (n == snoop_at) begin snoop = 1'b1; hit_modified = 1'b1; end
      if (n == abort_at) begin
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs",
               int'({req, frame, dbus_enb, data_last, writeback, busy, time_out}), 0);
        dbusy_n = 1'b1;
        return;
      end
      cyc(1);
      snoop = 1'b0; hit_modified = 1'b0;
      n++;
    end
    dbusy_n = 1'b1;
    chk("burst_ended", int'(frame), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    chk("reset_outputs", int'({req, frame, dbus_enb, data_last, writeback, busy, time_out}), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(2);
    chk("idle_after_reset", int'(busy), 0);

    // T1: 3-beat burst, grant +2, dgrant +1
    push(0, 3, 3, 0);
    issue(3, 0);
    serve(2, 1, 0, -1, -1);
    chk("t1_busy_drop", int'(busy), 0);
    cyc(2);

    // T2: len=0 -> 16 beats, dbusy_n 1,0,... -> 31 frame cycles
    push(0, 16, 31, 0);
    issue(0, 0);
    serve(0, 0, 1, -1, -1);
    cyc(2);

    // T3: no grant -> 32 req cycles, one time_out pulse, then a later go works
    push(1, 32, 0, 0);
    issue(2, 0);
    n = 0;
    while (!time_out && n < 60) begin cyc(1); n++; end
    chk("t3_timeout_seen", int'(time_out), 1);
    chk("t3_idle_at_timeout", int'(busy), 0);
    cyc(1);
    chk("t3_pulse_one_cycle", int'(time_out), 0);
    push(0, 2, 2, 0);
    issue(2, 0);
    serve(1, 0, 0, -1, -1);
    cyc(2);

    // T4: go + snoop hit together -> 4-beat writeback, go dropped
    push(0, 4, 4, 1);
    issue(7, 1);
    serve(0, 0, 0, -1, -1);
    cyc(4);
    chk("t4_go_dropped", int'({req, busy}), 0);

    // T5: hit during 5-beat burst -> burst completes, writeback follows at once
    push(0, 5, 5, 0);
    push(0, 4, 4, 1);
    issue(5, 0);
    serve(1, 1, 0, 2, -1);
    cyc(1);
    chk("t5_wb_immediate", int'(req), 1);
    serve(0, 0, 0, -1, -1);
    cyc(2);

    // T6: reset in beat 2 of 8 with a writeback pending
    issue(8, 0);
    serve(0, 0, 0, 0, 1);
    cyc(3);
    reset_n = 1'b1;
    cyc(6);
    chk("t6_idle_no_wb", int'({req, busy, writeback}), 0);

    cyc(2);
    chk("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
